// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box tables and GF(2^8) / key-schedule helpers.
package aes_pkg;

    localparam int AES_ROUNDS = 10;
    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} aes_state_e;

    // Entry x sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Undo xtime: odd values had the 0x1b reduction applied to a byte with bit 7 set.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte 0 is the most significant byte; bytes are column-major (index = 4*col + row).
    function automatic logic [7:0] get_byte(input logic [127:0] w, input int idx);
        return w[127 - 8 * idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         last_round_i,
    output logic [127:0] state_o
);

    logic [7:0] ark [16];

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                // Row r rotates right by r, so output column c reads input column c-r.
                ark[4*c+r] = inv_sbox(get_byte(state_i, 4 * ((c + 4 - r) % 4) + r))
                             ^ get_byte(rk_i, 4 * c + r);
            end
        end
    end

    always_comb begin
        state_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                state_o[127 - 8 * (4*c+r) -: 8] = last_round_i ? ark[4*c+r] :
                    gmul(ark[4*c + r],           8'h0e) ^
                    gmul(ark[4*c + (r + 1) % 4], 8'h0b) ^
                    gmul(ark[4*c + (r + 2) % 4], 8'h0d) ^
                    gmul(ark[4*c + (r + 3) % 4], 8'h09);
            end
        end
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then ten inverse rounds.
// Optional rk10 cache for repeated keys is enabled by defining AES_DEC_KEY_CACHE_EN.
module aes128_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         valid_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic         done,
    output logic         ready
);

    aes_state_e   st_q;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [7:0]   rcon_q;
    logic [3:0]   cnt_q;

    logic [127:0] key_fwd;
    logic [127:0] key_inv;
    logic [127:0] round_out;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key_q;
    logic [127:0] cache_rk_q;
    logic         cache_vld_q;
    logic         cache_hit;

    assign cache_hit = cache_vld_q && (key_in == cache_key_q);
`endif

    assign key_fwd = key_step_fwd(key_q, rcon_q);
    assign key_inv = key_step_inv(key_q, rcon_q);

    aes_inv_round u_inv_round (
        .state_i      (state_q),
        .rk_i         (key_inv),
        .last_round_i (cnt_q == 4'd0),
        .state_o      (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            state_q     <= '0;
            key_q       <= '0;
            rcon_q      <= RCON_FIRST;
            cnt_q       <= 4'd0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            done        <= 1'b0;
            ready       <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            case (st_q)
                IDLE: begin
                    if (start && valid_in && ready) begin
                        ready   <= 1'b0;
                        state_q <= data_in;
                        key_q   <= key_in;
                        rcon_q  <= RCON_FIRST;
                        cnt_q   <= 4'd1;
                        st_q    <= KEYEXP;
`ifdef AES_DEC_KEY_CACHE_EN
                        // Later assignments override the base flow on a hit.
                        if (cache_hit) begin
                            state_q <= data_in ^ cache_rk_q;
                            key_q   <= cache_rk_q;
                            rcon_q  <= RCON_LAST;
                            cnt_q   <= 4'(AES_ROUNDS - 1);
                            st_q    <= ROUND;
                        end else begin
                            cache_key_q <= key_in;
                            cache_vld_q <= 1'b0;
                        end
`endif
                    end
                end
                KEYEXP: begin
                    key_q  <= key_fwd;
                    rcon_q <= xtime(rcon_q);
                    if (cnt_q == 4'(AES_ROUNDS)) begin
                        state_q <= state_q ^ key_fwd;
                        rcon_q  <= RCON_LAST;
                        cnt_q   <= 4'(AES_ROUNDS - 1);
                        st_q    <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                        cache_rk_q  <= key_fwd;
                        cache_vld_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    key_q   <= key_inv;
                    rcon_q  <= inv_xtime(rcon_q);
                    if (cnt_q == 4'd0) begin
                        data_out  <= round_out;
                        valid_out <= 1'b1;
                        done      <= 1'b1;
                        ready     <= 1'b1;
                        rcon_q    <= RCON_FIRST;
                        st_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench: known FIPS-197 vectors plus random plaintexts run through a forward-cipher model.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         valid_in;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [127:0] data_out;
    logic         valid_out;
    logic         done;
    logic         ready;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HitLat = 10;
`else
    localparam int HitLat = 20;
`endif

    localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ZCt   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_decrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .key_in    (key_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .done      (done),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (forward cipher from GF(2^8) math) ----------------
    bit [7:0] sb [256];

    function automatic bit [7:0] gf_mul(input bit [7:0] a, input bit [7:0] b);
        bit [7:0] p, x;
        bit hi;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            hi = x[7];
            x = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic bit [7:0] rotl8(input bit [7:0] v, input int n);
        bit [15:0] d;
        d = {v, v};
        return d[15 - n -: 8];
    endfunction

    task automatic build_sbox();
        bit [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        bit [31:0] w [44];
        bit [31:0] tw;
        bit [7:0] rc;
        bit [7:0] s [16];
        bit [7:0] t [16];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gf_mul(t[4*c], 2) ^ gf_mul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 2) ^ gf_mul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 2) ^ gf_mul(t[4*c+3], 3);
                    s[4*c+3] = gf_mul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one request and observes 31 cycles; no checking here.
    task automatic run_op(input logic [127:0] key, input logic [127:0] ct, output int lat,
                          output logic [127:0] dout, output int pulses, output logic rdy0,
                          output int coinc);
        @(negedge clk);
        start = 1'b1; valid_in = 1'b1; key_in = key; data_in = ct;
        @(posedge clk);
        #1;
        start = 1'b0; valid_in = 1'b0; key_in = rnd128(); data_in = rnd128();
        lat = -1; dout = '0; pulses = 0; rdy0 = 1'b1; coinc = 0;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (k == 0) rdy0 = ready;
            if (valid_out !== done) coinc++;
            if (valid_out === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    dout = data_out;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (data_out !== 128'h0) $display("FAIL reset_data_out: got %h want 0", data_out); else n_pass++;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_fips_c1();
        int lat, pulses, coinc;
        logic [127:0] dout;
        logic rdy0;
        run_op(C1Key, C1Ct, lat, dout, pulses, rdy0, coinc);
        n_checks++; if (dout !== C1Pt) $display("FAIL c1_data: got %h want %h", dout, C1Pt); else n_pass++;
        n_checks++; if (lat != 20) $display("FAIL c1_latency: got %0d want 20", lat); else n_pass++;
        n_checks++; if (pulses != 1) $display("FAIL c1_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL c1_ready_busy: got %b want 0", rdy0); else n_pass++;
        n_checks++; if (coinc != 0) $display("FAIL c1_done_coincident: got %0d want 0", coinc); else n_pass++;
    endtask

    task automatic test_fips_b();
        int lat, pulses, coinc;
        logic [127:0] dout;
        logic rdy0;
        run_op(BKey, BCt, lat, dout, pulses, rdy0, coinc);
        n_checks++; if (dout !== BPt) $display("FAIL b_data: got %h want %h", dout, BPt); else n_pass++;
        n_checks++; if (lat != 20) $display("FAIL b_latency: got %0d want 20", lat); else n_pass++;
    endtask

    task automatic test_busy_start();
        int lat, pulses;
        logic [127:0] dout;
        @(negedge clk);
        start = 1'b1; valid_in = 1'b1; key_in = '0; data_in = ZCt;
        @(posedge clk);
        #1;
        start = 1'b0; valid_in = 1'b0;
        lat = -1; dout = '1; pulses = 0;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    dout = data_out;
                end
            end
            // Request while busy, then start without valid_in while idle: both ignored.
            if (k == 5) begin
                start = 1'b1; valid_in = 1'b1; key_in = rnd128(); data_in = rnd128();
            end else if (k == 20) begin
                start = 1'b1; valid_in = 1'b0;
            end else begin
                start = 1'b0; valid_in = 1'b0;
            end
        end
        n_checks++; if (dout !== 128'h0) $display("FAIL zero_data: got %h want 0", dout); else n_pass++;
        n_checks++; if (lat != 20) $display("FAIL zero_latency: got %0d want 20", lat); else n_pass++;
        n_checks++; if (pulses != 1) $display("FAIL busy_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL nostart_ready: got %b want 1", ready); else n_pass++;
    endtask

    task automatic test_random();
        int lat, pulses, coinc;
        logic [127:0] dout, k, p;
        logic rdy0;
        for (int i = 0; i < 6; i++) begin
            k = rnd128();
            p = rnd128();
            run_op(k, aes_encrypt(p, k), lat, dout, pulses, rdy0, coinc);
            n_checks++; if (dout !== p) $display("FAIL rand%0d_data: got %h want %h", i, dout, p); else n_pass++;
            n_checks++; if (lat != 20) $display("FAIL rand%0d_latency: got %0d want 20", i, lat); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k [8];
        logic [127:0] p [8];
        logic [127:0] c [8];
        int lat;
        for (int i = 0; i < 8; i++) begin
            k[i] = rnd128();
            p[i] = rnd128();
            c[i] = aes_encrypt(p[i], k[i]);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            start = 1'b1; valid_in = 1'b1; key_in = k[i]; data_in = c[i];
            @(posedge clk);
            #1;
            start = 1'b0; valid_in = 1'b0;
            lat = -1;
            for (int j = 0; j <= 30; j++) begin
                @(negedge clk);
                if (valid_out === 1'b1) begin
                    lat = j;
                    break;
                end
            end
            n_checks++; if (data_out !== p[i]) $display("FAIL b2b%0d_data: got %h want %h", i, data_out, p[i]); else n_pass++;
            n_checks++; if (lat != 20) $display("FAIL b2b%0d_latency: got %0d want 20", i, lat); else n_pass++;
        end
    endtask

    task automatic test_key_repeat();
        int lat, pulses, coinc;
        logic [127:0] dout, p;
        logic rdy0;
        p = rnd128();
        run_op(C1Key, aes_encrypt(p, C1Key), lat, dout, pulses, rdy0, coinc);
        n_checks++; if (lat != 20) $display("FAIL rep_first_latency: got %0d want 20", lat); else n_pass++;
        p = rnd128();
        run_op(C1Key, aes_encrypt(p, C1Key), lat, dout, pulses, rdy0, coinc);
        n_checks++; if (dout !== p) $display("FAIL rep_hit_data: got %h want %h", dout, p); else n_pass++;
        n_checks++; if (lat != HitLat) $display("FAIL rep_hit_latency: got %0d want %0d", lat, HitLat); else n_pass++;
        n_checks++; if (pulses != 1) $display("FAIL rep_hit_pulses: got %0d want 1", pulses); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p = rnd128();
        run_op(C1Key, aes_encrypt(p, C1Key), lat, dout, pulses, rdy0, coinc);
        n_checks++; if (dout !== p) $display("FAIL rep_after_rst_data: got %h want %h", dout, p); else n_pass++;
        n_checks++; if (lat != 20) $display("FAIL rep_after_rst_latency: got %0d want 20", lat); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat, pulses, coinc;
        logic [127:0] dout;
        logic rdy0;
        @(negedge clk);
        start = 1'b1; valid_in = 1'b1; key_in = C1Key; data_in = C1Ct;
        @(posedge clk);
        #1;
        start = 1'b0; valid_in = 1'b0;
        pulses = 0;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (valid_out === 1'b1 || done === 1'b1) pulses++;
            // Asserted between edges N+6 and N+7 so edge N+7 samples it.
            if (k == 6) rst = 1'b1;
            if (k == 7) rst = 1'b0;
        end
        n_checks++; if (pulses != 0) $display("FAIL abort_pulses: got %0d want 0", pulses); else n_pass++;
        n_checks++; if (data_out !== 128'h0) $display("FAIL abort_data_out: got %h want 0", data_out); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else n_pass++;
        run_op(C1Key, C1Ct, lat, dout, pulses, rdy0, coinc);
        n_checks++; if (dout !== C1Pt) $display("FAIL post_abort_data: got %h want %h", dout, C1Pt); else n_pass++;
        n_checks++; if (lat != 20) $display("FAIL post_abort_latency: got %0d want 20", lat); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = '0; key_in = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_busy_start();
        test_random();
        test_back_to_back();
        test_key_repeat();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1);
    end

endmodule
